// File: rtl/lstm_cell_update.sv
// LSTM cell update stage: hard activations, cell-state update and hidden-state output in a 3-stage valid/ready pipeline.
// Define LSTM_CELL_CLIP_EN to clamp the stored cell state to [-CELL_CLIP, +CELL_CLIP].
module lstm_cell_update #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int CELL_CLIP   = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         seq_start,
    input  logic signed [DATA_WIDTH-1:0] i_pre,
    input  logic signed [DATA_WIDTH-1:0] f_pre,
    input  logic signed [DATA_WIDTH-1:0] g_pre,
    input  logic signed [DATA_WIDTH-1:0] o_pre,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] h_out,
    output logic signed [DATA_WIDTH-1:0] c_out
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH + 1;

    localparam logic signed [DW-1:0] ONE     = DW'(1) <<< FRACT_WIDTH;
    localparam logic signed [DW-1:0] NEG_ONE = -ONE;
    localparam logic signed [DW-1:0] HALF    = DW'(1) <<< (FRACT_WIDTH - 1);
    localparam logic signed [PW-1:0] SAT_MAX = (PW'(1) <<< (DW - 1)) - PW'(1);
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [DW-1:0] CLIP_HI = DW'(CELL_CLIP);
    localparam logic signed [DW-1:0] CLIP_LO = -CLIP_HI;
`ifdef LSTM_CELL_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    // x>>>2 plus one half cannot overflow DW bits, so the clamp works in-width.
    function automatic logic signed [DW-1:0] hard_sig(input logic signed [DW-1:0] x);
        logic signed [DW-1:0] t;
        t = (x >>> 2) + HALF;
        if (t < 0)
            return '0;
        else if (t > ONE)
            return ONE;
        else
            return t;
    endfunction

    function automatic logic signed [DW-1:0] hard_tanh(input logic signed [DW-1:0] x);
        if (x < NEG_ONE)
            return NEG_ONE;
        else if (x > ONE)
            return ONE;
        else
            return x;
    endfunction

    logic                 adv;
    logic                 v1_q, ss1_q, v2_q, out_valid_q;
    logic signed [DW-1:0] i1_q, f1_q, g1_q, o1_q;
    logic signed [DW-1:0] c_state_q, c2_q, o2_q, h_q, c_q;

    assign adv       = ~out_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign h_out     = h_q;
    assign c_out     = c_q;

    // Stage 1: registered activations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            ss1_q <= 1'b0;
            i1_q  <= '0;
            f1_q  <= '0;
            g1_q  <= '0;
            o1_q  <= '0;
        end else if (adv) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            v1_q <= in_valid;
            if (in_valid) begin
                ss1_q <= seq_start;
                i1_q  <= hard_sig(i_pre);
                f1_q  <= hard_sig(f_pre);
                g1_q  <= hard_tanh(g_pre);
                o1_q  <= hard_sig(o_pre);
            end
        end
    end

    logic signed [DW-1:0]   cp, c_sat, c_new_d, h_d;
    logic signed [2*DW-1:0] fc_prod, ig_prod, h_prod;
    logic signed [PW-1:0]   c_sum, c_shift;

    always_comb begin
        // NOTE: every combinational output is assigned on all paths, so no latch is inferred.
        cp      = ss1_q ? '0 : c_state_q;
        fc_prod = (2*DW)'(f1_q) * (2*DW)'(cp);
        ig_prod = (2*DW)'(i1_q) * (2*DW)'(g1_q);
        c_sum   = PW'(fc_prod) + PW'(ig_prod);
        c_shift = c_sum >>> FRACT_WIDTH;
        if (c_shift > SAT_MAX)
            c_sat = SAT_MAX[DW-1:0];
        else if (c_shift < SAT_MIN)
            c_sat = SAT_MIN[DW-1:0];
        else
            c_sat = c_shift[DW-1:0];
        c_new_d = c_sat;
        if (CLIP_EN && (c_sat > CLIP_HI))
            c_new_d = CLIP_HI;
        else if (CLIP_EN && (c_sat < CLIP_LO))
            c_new_d = CLIP_LO;
        h_prod = (2*DW)'(o2_q) * (2*DW)'(hard_tanh(c2_q));
        h_d    = DW'(h_prod >>> FRACT_WIDTH);
    end

    // Stage 2: cell update; c_state closes its feedback loop within one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q      <= 1'b0;
            c2_q      <= '0;
            o2_q      <= '0;
            c_state_q <= '0;
        end else if (adv) begin
            v2_q <= v1_q;
            if (v1_q) begin
                c2_q      <= c_new_d;
                o2_q      <= o1_q;
                c_state_q <= c_new_d;
            end
        end
    end

    // Stage 3: output registers, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            h_q         <= '0;
            c_q         <= '0;
        end else if (adv) begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                h_q <= h_d;
                c_q <= c2_q;
            end
        end
    end

endmodule

// File: tb/tb_lstm_cell_update.sv
// Directed, table-driven bench for lstm_cell_update: vectors carry hand-computed h/c, an in-order queue matches outputs.
// Expectations follow the build: LSTM_CELL_CLIP_EN changes the saturation sequence.
module tb_lstm_cell_update;

    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid, in_ready, seq_start, out_valid, out_ready;
    logic signed [DW-1:0] i_pre, f_pre, g_pre, o_pre, h_out, c_out;

    always #5 clk = ~clk;

    lstm_cell_update #(.DATA_WIDTH(16), .FRACT_WIDTH(8), .CELL_CLIP(1024)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .seq_start (seq_start),
        .i_pre     (i_pre),
        .f_pre     (f_pre),
        .g_pre     (g_pre),
        .o_pre     (o_pre),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .h_out     (h_out),
        .c_out     (c_out)
    );

    typedef struct {
        logic                 bubble;
        logic                 ss;
        logic signed [DW-1:0] ip, fp, gp, op;
        logic signed [DW-1:0] eh, ec;
    } vec_t;

    typedef struct {
        logic signed [DW-1:0] eh, ec;
        int                   acc;
        int                   idx;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_start = 0;
    int   stall_len = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic bubble, input logic ss, input int ip, input int fp, input int gp,
                       input int op, input int eh, input int ec);
        vec_t v;
        v.bubble = bubble;
        v.ss = ss;
        v.ip = DW'(ip);
        v.fp = DW'(fp);
        v.gp = DW'(gp);
        v.op = DW'(op);
        v.eh = DW'(eh);
        v.ec = DW'(ec);
        vecs.push_back(v);
    endtask

    // Streams the vector table, matching each consumed output against the in-order expectation queue.
    task automatic run(input string tag, input int budget);
        int k = 0;
        int t = 0;
        exp_t e;
        while (k < vecs.size() || expq.size() != 0) begin
            @(negedge clk);
            cyc++;
            out_ready = !((t >= stall_start) && (t < stall_start + stall_len));
            t++;
            if (k < vecs.size()) begin
                in_valid  = !vecs[k].bubble;
                seq_start = vecs[k].ss;
                i_pre     = vecs[k].ip;
                f_pre     = vecs[k].fp;
                g_pre     = vecs[k].gp;
                o_pre     = vecs[k].op;
            end else begin
                in_valid  = 1'b0;
                seq_start = 1'b0;
            end
            #1;
            if (out_valid && !out_ready)
                check({tag, " in_ready under stall"}, in_ready, 0);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check({tag, " unexpected output"}, out_valid, 0);
                end else begin
                    e = expq.pop_front();
                    check($sformatf("%s c_out[%0d]", tag, e.idx), c_out, e.ec);
                    check($sformatf("%s h_out[%0d]", tag, e.idx), h_out, e.eh);
                    if (stall_len == 0)
                        check($sformatf("%s latency[%0d]", tag, e.idx), cyc - e.acc, 3);
                end
            end
            if (k < vecs.size()) begin
                if (vecs[k].bubble) begin
                    k++;
                end else if (in_ready) begin
                    e.eh  = vecs[k].eh;
                    e.ec  = vecs[k].ec;
                    e.acc = cyc;
                    e.idx = k;
                    expq.push_back(e);
                    k++;
                end
            end
            if (t > budget) begin
                check({tag, " timeout, outstanding"}, expq.size() + vecs.size() - k, 0);
                break;
            end
        end
        @(negedge clk);
        cyc++;
        in_valid  = 1'b0;
        seq_start = 1'b0;
        out_ready = 1'b1;
        #1;
        check({tag, " idle after drain"}, out_valid, 0);
        vecs.delete();
        expq.delete();
        stall_start = 0;
        stall_len = 0;
    endtask

    initial begin
        int c_exp;
        rst_n = 1'b0;
        in_valid = 1'b0;
        seq_start = 1'b0;
        i_pre = '0;
        f_pre = '0;
        g_pre = '0;
        o_pre = '0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset h_out", h_out, 0);
        check("reset c_out", c_out, 0);
        check("reset in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Fill the pipeline behind a stalled consumer, then reset with samples in flight.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        seq_start = 1'b1;
        i_pre = 16'sd1024;
        f_pre = 16'sd1024;
        g_pre = 16'sd256;
        o_pre = 16'sd1024;
        repeat (4) @(negedge clk);
        #1;
        check("pre-reset out_valid", out_valid, 1);
        check("pre-reset c_out", c_out, 256);
        check("pre-reset in_ready", in_ready, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid reset out_valid", out_valid, 0);
        check("mid reset h_out", h_out, 0);
        check("mid reset c_out", c_out, 0);
        in_valid = 1'b0;
        seq_start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // First sample after reset: c_state restarts at 0 even without seq_start.
        add(0, 0, 1024, 1024, 256, 1024, 256, 256);
        run("post-reset", 20);

        // Zero inputs, mid-range activations, floor rounding of negatives.
        add(0, 1,    0,    0,    0,     0,   0,   0);
        add(0, 0,    0,    0,  200,     0,  50, 100);
        add(0, 0, -100,  200,  -50,  -600,   0,  49);
        add(0, 1,    1,    0,   -3,  1024,  -2,  -2);
        add(0, 0, -1024,  -3,   50,  1024,  -1,  -1);
        run("basic", 30);

        // Accumulation with bubbles carrying a stray seq_start that must be ignored.
        add(0, 1, 1024, 1024, 256, 1024, 256, 256);
        add(1, 1,  -77,   -9, -999,   13,   0,   0);
        add(0, 0, 1024, 1024, 256, 1024, 256, 512);
        add(1, 1,  555,  -44,   12,  -80,   0,   0);
        add(0, 0, 1024, 1024, 256, 1024, 256, 768);
        add(0, 1, 1024, 1024, 256, 1024, 256, 256);
        add(0, 0, 1024, 1024, 256, 1024, 256, 512);
        add(0, 0, 1024, 1024, 256, 1024, 256, 768);
        run("accumulate", 40);

        // Negative candidate, zeroed forget gate, saturating tanh input.
        add(0, 1, 1024,   500, -300, 1024, -256, -256);
        add(0, 0, 1024, -1024,  100, 1024,  100,  100);
        add(0, 1, 1024,     0, 5000,    0,  128,  256);
        run("negative", 30);

        // Consumer stalls for 5 cycles while 3 samples stream in.
        add(0, 1, 1024, 1024, 256, 1024, 256, 256);
        add(0, 0, 1024, 1024, 256, 1024, 256, 512);
        add(0, 0, 1024, 1024, 256, 1024, 256, 768);
        stall_start = 0;
        stall_len = 5;
        run("backpressure", 40);

        // Long accumulation to the saturation (or clip) limit.
        for (int n = 1; n <= 130; n++) begin
            c_exp = 256 * n;
`ifdef LSTM_CELL_CLIP_EN
            if (c_exp > 1024) c_exp = 1024;
`else
            if (c_exp > 32767) c_exp = 32767;
`endif
            add(0, (n == 1), 1024, 1024, 256, 1024, 256, c_exp);
        end
        run("saturate", 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lstm_cell_update.md
Name: lstm_cell_update

Overview:
Downstream stage of the four gate pre-activation units (input i, forget f, candidate g, output o). Each unit produces a Q8.8 value of the form W0*X + W1*h_in + b.
- Applies hard-sigmoid and hard-tanh activations.
- Updates the stored cell state c and produces the new hidden state h.
- h feeds back as h_in for the next time step.
- 3-stage pipeline with valid/ready handshake; one sample per cycle when not stalled.

Parameters:
DATA_WIDTH, 16, width of all signed fixed-point data words
FRACT_WIDTH, 8, fractional bits (Q8.8 at defaults)
CELL_CLIP, 1024, magnitude limit for c (4.0 in Q8.8); used only with LSTM_CELL_CLIP_EN

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  gate pre-activations valid this cycle
in_ready  output  1  stage accepts input this cycle
seq_start  input  1  sample is first of a sequence; previous c treated as 0
i_pre  input  DATA_WIDTH  signed input-gate pre-activation
f_pre  input  DATA_WIDTH  signed forget-gate pre-activation
g_pre  input  DATA_WIDTH  signed candidate pre-activation
o_pre  input  DATA_WIDTH  signed output-gate pre-activation
out_valid  output  1  h_out/c_out valid
out_ready  input  1  consumer accepts output
h_out  output  DATA_WIDTH  signed new hidden state
c_out  output  DATA_WIDTH  signed new cell state

Behaviour:
Reset and pipeline control
- Reset (async, rst_n=0): all stage valid bits 0; c_state, h_out and c_out 0; out_valid 0. Reset mid-operation discards all in-flight samples.
- Advance: adv = ~out_valid | out_ready. in_ready = adv (combinational). All stages shift only when adv=1; otherwise all hold.
- Input accepted when in_valid & in_ready. A bubble (in_valid=0 while adv=1) propagates as valid=0.
- Latency: exactly 3 advancing cycles from acceptance to out_valid. Throughput: 1 sample per cycle with out_ready held 1.

Activations (S1, registered)
- sig(x) = clamp((x>>>2) + 2^(FRACT_WIDTH-1), 0, 2^FRACT_WIDTH). At defaults: clamp((x>>>2)+128, 0, 256).
- tanh_h(x) = clamp(x, -2^FRACT_WIDTH, +2^FRACT_WIDTH).
- S1 registers: i=sig(i_pre), f=sig(f_pre), g=tanh_h(g_pre), o=sig(o_pre), plus seq_start.

Cell update (S2)
- cp = seq_start_s1 ? 0 : c_state.
- c_new = sat((f*cp + i*g) >>> FRACT_WIDTH).
  - Products are full 2*DATA_WIDTH; the sum uses 2*DATA_WIDTH+1 bits.
  - >>> is arithmetic (floor, no rounding).
  - sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- c_state <= c_new only when S1 holds a valid sample and adv=1. Bubbles and stalls leave c_state unchanged.
- c_new and o are forwarded to S3.

Output (S3)
- h = (o * tanh_h(c_new)) >>> FRACT_WIDTH. No saturation needed, since |h| <= 2^FRACT_WIDTH.
- h_out and c_out are registered and hold their values while out_valid & ~out_ready.

Boundary conditions
- seq_start with in_valid=0: ignored.
- Back-to-back samples: the S2 c_state feedback closes within one cycle, so sample t+1 sees c from sample t with no hazard.

Optional Feature:
Macro: LSTM_CELL_CLIP_EN.
- Defined: after sat, c_new is clamped to [-CELL_CLIP, +CELL_CLIP]. The clamped value is stored in c_state and output as c_out.
- Undefined: only the DATA_WIDTH saturation applies; CELL_CLIP is unused.

Test Plan:
1. Reset: assert rst_n=0 mid-stream with samples in flight -> out_valid=0, h_out=0, c_out=0 immediately. After release, the first new sample emerges exactly 3 cycles after acceptance.
2. Zero inputs: seq_start=1, all pre=0 -> c_out=0, h_out=0; S1 values i=f=o=128, g=0.
3. Accumulation, three back-to-back samples, i_pre=f_pre=o_pre=1024, g_pre=256, seq_start only on the first -> c_out = 256, 512, 768 and h_out = 256, 256, 256, on 3 consecutive cycles.
4. Negatives: seq_start=1, i_pre=1024, g_pre=-300, o_pre=1024 -> g=-256, c_out=-256, h_out=-256. Next sample f_pre=-1024 (f=0) -> c_out = (256*g)>>>8 of the new g only.
5. Backpressure: out_ready=0 for 5 cycles while 3 valid samples stream -> in_ready drops once out_valid=1; no sample lost or duplicated; c_state is advanced by each sample exactly once; outputs drain in order after out_ready=1.
6. Saturation: repeated i=f=256, g=256 samples with no seq_start.
   - Without macro: c_out saturates at 32767.
   - With LSTM_CELL_CLIP_EN: c_out steps 256, 512, 768, 1024, 1024, with h_out=256 throughout.
